// File: rtl/spi_monitor_framer_if.sv
// spi_monitor_framer_if: SPI receive strobe bundle and UART transmit handshake.
// slave = framer side, master = SPI/UART environment side.
interface spi_monitor_framer_if;
    logic       spi_rx_strobe;
    logic       spi_rx_cmd;
    logic [7:0] spi_rx_data;
    logic [7:0] spi_rx_miso;
    logic [7:0] uart_txd;
    logic       uart_txd_strobe;
    logic       uart_txd_ready;

    modport master (
        output spi_rx_strobe,
        output spi_rx_cmd,
        output spi_rx_data,
        output spi_rx_miso,
        input  uart_txd,
        input  uart_txd_strobe,
        output uart_txd_ready
    );

    modport slave (
        input  spi_rx_strobe,
        input  spi_rx_cmd,
        input  spi_rx_data,
        input  spi_rx_miso,
        output uart_txd,
        output uart_txd_strobe,
        input  uart_txd_ready
    );
endinterface

// File: rtl/spi_monitor_framer.sv
// spi_monitor_framer: SPI bytes -> {index, mosi, miso} records -> FIFO -> UART bytes.
// Define SPI_MONITOR_DROP_MARKER_EN to inject {FFFF, dropped} marker records after drops.
module spi_monitor_framer #(
    parameter int          FIFO_ADDR_BITS = 6,
    parameter logic [15:0] INDEX_MAX      = 16'hFFFE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    spi_monitor_framer_if.slave     bus,
    output logic [FIFO_ADDR_BITS:0] fifo_level,
    output logic [15:0]             dropped,
    output logic                    overflow
);
    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int LW    = FIFO_ADDR_BITS + 1;
    localparam int AW    = FIFO_ADDR_BITS;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [15:0]      idx_cnt;
    logic             accept;
    logic             push_vld;
    logic [31:0]      push_rec;
    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [31:0]      shift;
    logic [2:0]       bytes_left;
    logic             pop;
    logic             full;
    logic             free;
    logic             inject;
    logic             wr_en;
    logic             drop;
    logic [31:0]      wr_data;

    assign accept = enable && bus.spi_rx_strobe;

    // Stamp each accepted SPI byte with its position index.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_cnt  <= 16'h0000;
            push_vld <= 1'b0;
            push_rec <= 32'h0;
        end else begin
            push_vld <= accept;
            if (accept) begin
                if (bus.spi_rx_cmd) begin
                    push_rec <= {16'h0000, bus.spi_rx_data, bus.spi_rx_miso};
                    idx_cnt  <= 16'h0001;
                end else begin
                    push_rec <= {idx_cnt, bus.spi_rx_data, bus.spi_rx_miso};
                    if (idx_cnt < INDEX_MAX) begin
                        idx_cnt <= idx_cnt + 16'h0001;
                    end
                end
            end
        end
    end

`ifdef SPI_MONITOR_DROP_MARKER_EN
    logic mk_pend;

    // One marker outstanding; later drops just raise the count it carries.
    always_ff @(posedge clk) begin
        if (reset) begin
            mk_pend <= 1'b0;
        end else begin
            mk_pend <= (mk_pend && !inject) || drop;
        end
    end
`endif

    // Write arbitration: a pop in the same cycle frees the slot of a full FIFO.
    always_comb begin
        pop    = (state == IDLE) && (fifo_level != '0);
        full   = (fifo_level == LW'(DEPTH));
        free   = !full || pop;
`ifdef SPI_MONITOR_DROP_MARKER_EN
        inject = mk_pend && free;
`else
        inject = 1'b0;
`endif
        wr_en   = inject || (push_vld && free);
        wr_data = inject ? {16'hFFFF, dropped} : push_rec;
        drop    = push_vld && (!free || inject);
    end

    // Record storage (no reset needed; validity tracked by pointers).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
        end
    end

    // Loss accounting: saturating drop count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped  <= 16'h0000;
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (dropped != 16'hFFFF) begin
                dropped <= dropped + 16'h0001;
            end
        end
    end

    // Serialiser: MSB byte first, one idle cycle after every strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            shift               <= 32'h0;
            bytes_left          <= 3'd0;
            bus.uart_txd        <= 8'h00;
            bus.uart_txd_strobe <= 1'b0;
        end else begin
            bus.uart_txd_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shift      <= mem[rd_ptr];
                        bytes_left <= 3'd4;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (bus.uart_txd_ready && !bus.uart_txd_strobe) begin
                        bus.uart_txd        <= shift[31:24];
                        bus.uart_txd_strobe <= 1'b1;
                        shift               <= {shift[23:0], 8'h00};
                        bytes_left          <= bytes_left - 3'd1;
                        if (bytes_left == 3'd1) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_monitor_framer.sv
// tb_spi_monitor_framer: directed stimulus with a byte scoreboard
// checked by an independent UART-side monitor.
module tb_spi_monitor_framer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [6:0]  fifo_level;
    logic [15:0] dropped;
    logic        overflow;

    spi_monitor_framer_if bus ();

    spi_monitor_framer #(
        .FIFO_ADDR_BITS (6),
        .INDEX_MAX      (16'hFFFE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .fifo_level (fifo_level),
        .dropped    (dropped),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         stb_q[$];
    int         n_stb = 0;
    logic       prev_rdy = 1'b0;
    logic       prev_stb = 1'b0;
    int         exp_idx = 0;
    int         last_sample = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every UART strobe pops one expected byte.
    always @(negedge clk) begin
        if (reset) begin
            prev_rdy = 1'b0;
            prev_stb = 1'b0;
        end else begin
            if (bus.uart_txd_strobe) begin
                n_stb++;
                stb_q.push_back(cyc);
                check("ready_before_strobe", 32'(prev_rdy), 32'd1);
                check("strobe_gap", 32'(prev_stb), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got %02h expected none", bus.uart_txd);
                end else begin
                    check("uart_byte", 32'(bus.uart_txd), 32'(exp_q.pop_front()));
                end
            end
            prev_rdy = bus.uart_txd_ready;
            prev_stb = bus.uart_txd_strobe;
        end
    end

    task automatic push_rec(input int idx, input logic [7:0] d, input logic [7:0] m);
        logic [15:0] i16;
        i16 = 16'(idx);
        exp_q.push_back(i16[15:8]);
        exp_q.push_back(i16[7:0]);
        exp_q.push_back(d);
        exp_q.push_back(m);
    endtask

    task automatic ev(input logic cmd, input logic [7:0] d, input logic [7:0] m,
                      input bit expect_out);
        int idx;
        @(posedge clk);
        #1;
        bus.spi_rx_strobe = 1'b1;
        bus.spi_rx_cmd    = cmd;
        bus.spi_rx_data   = d;
        bus.spi_rx_miso   = m;
        last_sample = cyc + 1;
        if (enable) begin
            idx = cmd ? 0 : exp_idx;
            if (cmd) exp_idx = 1;
            else if (exp_idx < 32'hFFFE) exp_idx++;
            if (expect_out) push_rec(idx, d, m);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.spi_rx_strobe = 1'b0;
        bus.spi_rx_cmd    = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("drain_left", 32'(exp_q.size()), 32'd0);
        cycles(4);
    endtask

    task automatic wait_left(input int left, input int limit);
        int n;
        n = 0;
        while (exp_q.size() > left && n < limit) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    task automatic check_reset_vals();
        check("rst_txd", 32'(bus.uart_txd), 32'h0);
        check("rst_strobe", 32'(bus.uart_txd_strobe), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_dropped", 32'(dropped), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
    endtask

    initial begin
        int n0;
        bus.spi_rx_strobe  = 1'b0;
        bus.spi_rx_cmd     = 1'b0;
        bus.spi_rx_data    = 8'h00;
        bus.spi_rx_miso    = 8'h00;
        bus.uart_txd_ready = 1'b1;
        cycles(3);
        check_reset_vals();
        reset  = 1'b0;
        enable = 1'b1;
        cycles(2);

        // Single event: 00 00 03 FF, latency 3, spacing 2
        stb_q.delete();
        ev(1'b1, 8'h03, 8'hFF, 1'b1);
        idle();
        drain(100);
        check("single_strobes", 32'(stb_q.size()), 32'd4);
        if (stb_q.size() == 4) begin
            check("latency", 32'(stb_q[0] - last_sample), 32'd3);
            for (int i = 1; i < 4; i++)
                check("spacing", 32'(stb_q[i] - stb_q[i-1]), 32'd2);
        end

        // Index sequence 0,1,2,3 then back to 0 on new cmd
        ev(1'b1, 8'h0B, 8'hC0, 1'b1);
        ev(1'b0, 8'h12, 8'hC1, 1'b1);
        ev(1'b0, 8'h34, 8'hC2, 1'b1);
        ev(1'b0, 8'h56, 8'hC3, 1'b1);
        ev(1'b1, 8'h0C, 8'hC4, 1'b1);
        idle();
        drain(200);

        // Backpressure mid-record
        for (int i = 0; i < 5; i++)
            ev(1'b0, 8'(8'h60 + i), 8'(8'h90 + i), 1'b1);
        idle();
        wait_left(18, 100);
        bus.uart_txd_ready = 1'b0;
        cycles(2);
        n0 = n_stb;
        check("bp_level", 32'(fifo_level), 32'd4);
        cycles(98);
        check("bp_no_strobe", 32'(n_stb), 32'(n0));
        bus.uart_txd_ready = 1'b1;
        drain(400);
        check("bp_level_end", 32'(fifo_level), 32'd0);

        // Overflow: one record held in serialiser, then 70 more
        bus.uart_txd_ready = 1'b0;
        ev(1'b1, 8'hA5, 8'h5A, 1'b1);
        idle();
        cycles(6);
        for (int i = 1; i <= 70; i++)
            ev(1'b0, 8'(i), 8'(~i), i <= 64);
        idle();
        cycles(3);
        check("ovf_level", 32'(fifo_level), 32'd64);
        check("ovf_dropped", 32'(dropped), 32'd6);
        check("ovf_flag", 32'(overflow), 32'd1);
`ifdef SPI_MONITOR_DROP_MARKER_EN
        push_rec(32'hFFFF, 8'h00, 8'h06);
`endif
        bus.uart_txd_ready = 1'b1;
        drain(3000);
        check("ovf_level_end", 32'(fifo_level), 32'd0);

        // enable low: strobe ignored, not a drop, index unchanged
        enable = 1'b0;
        n0 = n_stb;
        ev(1'b0, 8'hEE, 8'hEE, 1'b1);
        idle();
        cycles(10);
        check("dis_dropped", 32'(dropped), 32'd6);
        check("dis_level", 32'(fifo_level), 32'd0);
        check("dis_no_strobe", 32'(n_stb), 32'(n0));
        enable = 1'b1;
        ev(1'b0, 8'h71, 8'h17, 1'b1);
        idle();
        drain(100);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("dropped_held", 32'(dropped), 32'd6);

        // Reset after 2 bytes of a record
        ev(1'b0, 8'hAB, 8'hCD, 1'b1);
        idle();
        wait_left(2, 100);
        check("pre_reset_left", 32'(exp_q.size()), 32'd2);
        reset = 1'b1;
        exp_q.delete();
        cycles(2);
        check_reset_vals();
        reset   = 1'b0;
        exp_idx = 0;
        n0 = n_stb;
        cycles(20);
        check("post_reset_silent", 32'(n_stb), 32'(n0));
        ev(1'b0, 8'h77, 8'h88, 1'b1);
        idle();
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_monitor_framer.md
Name: spi_monitor_framer

Overview:
- Sits between spi_device and the uart in monitor mode.
- Captures every received SPI byte as a 4-byte record: 16-bit position index, MOSI byte, MISO byte.
- Buffers records in an event FIFO and serialises them to the uart with a proper txd_ready handshake.
- Counts, and never silently corrupts, events lost to overflow.

Parameters:
- FIFO_ADDR_BITS, 6, log2 of record FIFO depth (DEPTH = 64 records).
- INDEX_MAX, 16'hFFFE, saturation value of the byte index; 16'hFFFF is reserved for drop markers.

Ports:
- clk  input  1  system clock (132 MHz domain)
- reset  input  1  synchronous, active-high
- enable  input  1  capture enable; when low, new spi_rx_strobe events are ignored, not counted as drops
- spi_rx_strobe  input  1  one-cycle pulse per completed SPI byte
- spi_rx_cmd  input  1  qualifies spi_rx_strobe: byte is first after CS falling
- spi_rx_data  input  8  MOSI byte, valid with spi_rx_strobe
- spi_rx_miso  input  8  MISO byte, valid with spi_rx_strobe
- uart_txd  output  8  byte to uart
- uart_txd_strobe  output  1  one-cycle write pulse to uart
- uart_txd_ready  input  1  uart has FIFO space
- fifo_level  output  FIFO_ADDR_BITS+1  records currently stored
- dropped  output  16  saturating count of dropped records since reset
- overflow  output  1  sticky, set on first drop, cleared only by reset

Behaviour:
- Reset: uart_txd=0, uart_txd_strobe=0, fifo_level=0, dropped=0, overflow=0, byte index=0, serializer in IDLE. Reset mid-record abandons the record; no partial bytes after reset.
- Indexing: on an accepted strobe with spi_rx_cmd=1, record index=16'h0000 and the internal counter becomes 1. With spi_rx_cmd=0, record index=counter and the counter increments, saturating at INDEX_MAX.
- Record layout: {index[15:8], index[7:0], spi_rx_data, spi_rx_miso}, sent MSB byte first.
- Push: the record is written the cycle after the strobe.
- Full FIFO: the push is accepted if fifo_level<DEPTH, or if a pop occurs in the same cycle. Otherwise:
  - the record is discarded;
  - dropped increments, saturating at 16'hFFFF;
  - overflow is set.
  - The index counter still advances, so index gaps reveal the loss.
- Serializer states:
  - IDLE: if the FIFO is non-empty, pop into a 32-bit shift register, set bytes_left=4, go to SEND. The pop is registered, so SEND starts the next cycle.
  - SEND: if uart_txd_ready=1 and uart_txd_strobe was 0 in the previous cycle:
    - drive uart_txd=shift[31:24] and pulse uart_txd_strobe;
    - shift left 8;
    - decrement bytes_left;
    - at 0, return to IDLE.
  - The mandatory gap cycle absorbs the uart's one-cycle ready latency; throughput is at most one byte per 2 cycles.
  - uart_txd_ready low: hold state indefinitely, no timeout.
- uart_txd holds its last value when the strobe is low.
- Minimum latency from spi_rx_strobe (empty FIFO, ready high) to first uart_txd_strobe: 3 cycles.
- fifo_level reflects pushes and pops on the cycle after they occur; a simultaneous push and pop leaves it unchanged.
- enable deasserting mid-transaction does not affect records already queued or in flight.

Optional Feature:
- Macro: SPI_MONITOR_DROP_MARKER_EN.
- Defined:
  - After any drop, once the FIFO has a free slot, the block injects one marker record {16'hFFFF, dropped[15:8], dropped[7:0]} ahead of the next real record. The dropped value is sampled at injection.
  - Only one marker is pending at a time; further drops before injection update the value carried.
  - If a real push and a marker injection contend for the same slot, the marker wins and the real record counts as a drop.
- Undefined: no markers are emitted; drops are visible only via dropped/overflow.

Test Plan:
- Single event: strobe with cmd=1, data=8'h03, miso=8'hFF, ready held 1 -> uart bytes 00,00,03,FF in order, strobes spaced 2 cycles, first strobe 3 cycles after input strobe.
- Index sequence: cmd 0x0B then 3 data strobes (0x12, 0x34, 0x56) -> indices 0000, 0001, 0002, 0003; then a new cmd -> index returns to 0000.
- Backpressure: 5 queued records, ready toggled low for 100 cycles mid-record -> byte stream intact and in order, fifo_level decrements 5 to 0, no strobe while ready=0.
- Overflow: ready=0, 70 strobes -> fifo_level=64, dropped=6, overflow=1. With ready=1, 64 records drain, and indices jump by 6 after the last stored record.
- Reset mid-SEND after 2 bytes -> no further strobes, all outputs return to reset values, next event starts with index 0000.
- Macro defined, overflow test repeated -> after the first free slot, the stream contains FF,FF,00,06 before the next real record; macro undefined -> no FF,FF record.
